// File: rtl/range_window_bank.sv
// rtl/range_window_bank.sv - bank of independent counter-triggered range windows with lowest-index priority encode
//
// Purpose: each channel opens a window of `length` cycles one clock after the
// shared position counter equals its start value, then waits for a counter wrap
// before it can fire again. The lowest-numbered open window is reported for
// object selection.
//
// Ports:
//   clock, reset        clock and asynchronous active-low reset
//   load, load_channel  write load_start/load_length into one channel
//   load_start          turn-on count
//   load_length         window length in cycles, 0 disables the channel
//   clear_all           disarm every channel, stored start/length kept
//   counter_wrap        one-cycle strobe: shared counter restarted
//   counter             shared upward-counting position
//   active              per-channel window-open flag (registered)
//   elapsed             per-channel cycles since active rose (registered)
//   done                per-channel one-cycle pulse when the window closes
//   any_active          OR of active
//   first_active        lowest-numbered set active bit, 0 when none
module range_window_bank #(
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = 10,
    parameter int LENGTH_WIDTH  = 8,
    localparam int IDX_WIDTH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             load,
    input  logic [IDX_WIDTH-1:0]             load_channel,
    input  logic [COUNTER_WIDTH-1:0]         load_start,
    input  logic [LENGTH_WIDTH-1:0]          load_length,
    input  logic                             clear_all,
    input  logic                             counter_wrap,
    input  logic [COUNTER_WIDTH-1:0]         counter,
    output logic [CHANNELS-1:0]              active,
    output logic [CHANNELS*LENGTH_WIDTH-1:0] elapsed,
    output logic [CHANNELS-1:0]              done,
    output logic                             any_active,
    output logic [IDX_WIDTH-1:0]             first_active
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        SPENT  = 2'd3
    } state_t;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        state_t                   state_q, state_d;
        logic [COUNTER_WIDTH-1:0] start_q, start_d;
        logic [LENGTH_WIDTH-1:0]  length_q, length_d;
        logic [LENGTH_WIDTH-1:0]  elapsed_q, elapsed_d;
        logic                     active_q, active_d;
        logic                     done_q, done_d;
        logic                     target;

        // Only indices below CHANNELS exist, so out-of-range load_channel
        // values simply match no channel.
        assign target = load && (load_channel == IDX_WIDTH'(ch));

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_q   <= IDLE;
                start_q   <= '0;
                length_q  <= '0;
                elapsed_q <= '0;
                active_q  <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                start_q   <= start_d;
                length_q  <= length_d;
                elapsed_q <= elapsed_d;
                active_q  <= active_d;
                done_q    <= done_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            start_d   = start_q;
            length_d  = length_q;
            elapsed_d = elapsed_q;
            active_d  = active_q;
            done_d    = 1'b0;

            if (clear_all) begin
                // Stored start/length survive; a fresh load is needed to re-arm.
                state_d   = IDLE;
                active_d  = 1'b0;
                elapsed_d = '0;
            end else if (target) begin
                // Load wins over match, wrap and completion; an open window
                // is aborted silently.
                start_d   = load_start;
                length_d  = load_length;
                state_d   = (load_length != '0) ? ARMED : IDLE;
                active_d  = 1'b0;
                elapsed_d = '0;
            end else begin
                case (state_q)
                    ARMED: begin
                        if (counter == start_q) begin
                            state_d   = ACTIVE;
                            active_d  = 1'b1;
                            elapsed_d = '0;
                        end
                    end
                    ACTIVE: begin
                        // Wrap and further matches are ignored until the
                        // window has run its full length.
                        if (elapsed_q == length_q - LENGTH_WIDTH'(1)) begin
                            state_d   = SPENT;
                            active_d  = 1'b0;
                            elapsed_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            elapsed_d = elapsed_q + LENGTH_WIDTH'(1);
                        end
                    end
                    SPENT: begin
                        // A match coincident with the wrap is not taken.
                        if (counter_wrap) begin
                            state_d = ARMED;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end

        assign active[ch]                                  = active_q;
        assign done[ch]                                    = done_q;
        assign elapsed[ch*LENGTH_WIDTH +: LENGTH_WIDTH]    = elapsed_q;
    end

    assign any_active = |active;

    // Scan from the top so the lowest set index is written last.
    always_comb begin
        first_active = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (active[i]) begin
                first_active = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: tb/tb_range_window_bank.sv
// tb/tb_range_window_bank.sv - self-checking bench for range_window_bank
module tb_range_window_bank;

    localparam int CH = 4;
    localparam int CW = 10;
    localparam int LW = 8;
    localparam int IW = 2;

    logic            clock;
    logic            reset;
    logic            load;
    logic [IW-1:0]   load_channel;
    logic [CW-1:0]   load_start;
    logic [LW-1:0]   load_length;
    logic            clear_all;
    logic            counter_wrap;
    logic [CW-1:0]   counter;
    logic [CH-1:0]   active;
    logic [CH*LW-1:0] elapsed;
    logic [CH-1:0]   done;
    logic            any_active;
    logic [IW-1:0]   first_active;

    range_window_bank #(
        .CHANNELS(CH), .COUNTER_WIDTH(CW), .LENGTH_WIDTH(LW)
    ) dut (
        .clock(clock), .reset(reset), .load(load), .load_channel(load_channel),
        .load_start(load_start), .load_length(load_length), .clear_all(clear_all),
        .counter_wrap(counter_wrap), .counter(counter), .active(active),
        .elapsed(elapsed), .done(done), .any_active(any_active),
        .first_active(first_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a window is "cycles left to run"; a channel either
    // waits for its start, runs, or has fired and waits for a wrap.
    int m_start [CH];
    int m_len   [CH];
    int m_left  [CH];
    bit m_wait  [CH];
    bit m_spent [CH];
    bit m_done  [CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_start[i] = 0; m_len[i] = 0; m_left[i] = 0;
            m_wait[i] = 0; m_spent[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            m_done[i] = 0;
            if (clear_all) begin
                m_left[i] = 0; m_wait[i] = 0; m_spent[i] = 0;
            end else if (load && int'(load_channel) == i) begin
                m_start[i] = int'(load_start);
                m_len[i]   = int'(load_length);
                m_wait[i]  = (load_length != 0);
                m_left[i]  = 0;
                m_spent[i] = 0;
            end else if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_done[i]  = 1;
                    m_spent[i] = 1;
                end
            end else if (m_wait[i] && int'(counter) == m_start[i]) begin
                m_left[i] = m_len[i];
                m_wait[i] = 0;
            end else if (m_spent[i] && counter_wrap) begin
                m_spent[i] = 0;
                m_wait[i]  = 1;
            end
        end
    endtask

    task automatic check_all();
        logic [CH-1:0]    e_act;
        logic [CH*LW-1:0] e_el;
        logic [CH-1:0]    e_done;
        logic [IW-1:0]    e_first;
        e_act = '0; e_el = '0; e_done = '0; e_first = '0;
        for (int i = 0; i < CH; i++) begin
            e_act[i]  = (m_left[i] > 0);
            e_done[i] = m_done[i];
            if (m_left[i] > 0) e_el[i*LW +: LW] = LW'(m_len[i] - m_left[i]);
        end
        for (int i = CH - 1; i >= 0; i--) if (e_act[i]) e_first = IW'(i);
        chk("active", 64'(active), 64'(e_act));
        chk("elapsed", 64'(elapsed), 64'(e_el));
        chk("done", 64'(done), 64'(e_done));
        chk("any_active", 64'(any_active), 64'(|e_act));
        chk("first_active", 64'(first_active), 64'(e_first));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_all();
        load = 0; clear_all = 0; counter_wrap = 0;
    endtask

    task automatic do_load(input int ch, input int st, input int len);
        load = 1; load_channel = IW'(ch); load_start = CW'(st); load_length = LW'(len);
        tick();
    endtask

    task automatic ramp(input int from, input int to);
        for (int c = from; c <= to; c++) begin
            counter = CW'(c);
            tick();
        end
    endtask

    typedef struct {
        int             cnt;
        logic [CH-1:0]  e_act;
        logic [CH-1:0]  e_done;
        logic           e_any;
        logic [IW-1:0]  e_first;
    } vec_t;

    vec_t vtab [7];

    int n_act0, n_done0, maxel, r, cnt;

    initial begin
        vtab[0] = '{3, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vtab[1] = '{4, 4'b0010, 4'b0000, 1'b1, 2'd1};
        vtab[2] = '{5, 4'b0010, 4'b0000, 1'b1, 2'd1};
        vtab[3] = '{6, 4'b0110, 4'b0000, 1'b1, 2'd1};
        vtab[4] = '{7, 4'b0110, 4'b0000, 1'b1, 2'd1};
        vtab[5] = '{8, 4'b0000, 4'b0110, 1'b0, 2'd0};
        vtab[6] = '{9, 4'b0000, 4'b0000, 1'b0, 2'd0};

        reset = 0; load = 0; load_channel = '0; load_start = '0; load_length = '0;
        clear_all = 0; counter_wrap = 0; counter = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all();
        reset = 1;

        // Basic window
        do_load(0, 5, 3);
        n_act0 = 0; n_done0 = 0;
        for (int c = 0; c <= 20; c++) begin
            counter = CW'(c);
            tick();
            n_act0 += int'(active[0]);
            n_done0 += int'(done[0]);
        end
        chk("basic_active_cycles", 64'(n_act0), 64'd3);
        chk("basic_done_pulses", 64'(n_done0), 64'd1);

        // No wrap: no second window
        n_act0 = 0;
        for (int c = 0; c <= 20; c++) begin
            counter = CW'(c); tick(); n_act0 += int'(active[0]);
        end
        chk("no_rearm_without_wrap", 64'(n_act0), 64'd0);

        // Wrap re-arms; wrap coincident with match does not fire
        counter = CW'(5); counter_wrap = 1; tick();
        chk("wrap_match_not_taken", 64'(active[0]), 64'd0);
        n_act0 = 0;
        for (int c = 0; c <= 20; c++) begin
            counter = CW'(c); tick(); n_act0 += int'(active[0]);
        end
        chk("rearm_active_cycles", 64'(n_act0), 64'd3);

        // Overlap and priority (table)
        clear_all = 1; tick();
        do_load(1, 4, 4);
        do_load(2, 6, 2);
        ramp(0, 2);
        foreach (vtab[k]) begin
            counter = CW'(vtab[k].cnt);
            tick();
            chk("tab_active", 64'(active), 64'(vtab[k].e_act));
            chk("tab_done", 64'(done), 64'(vtab[k].e_done));
            chk("tab_any", 64'(any_active), 64'(vtab[k].e_any));
            chk("tab_first", 64'(first_active), 64'(vtab[k].e_first));
        end

        // Abort by load at elapsed=2
        clear_all = 1; tick();
        do_load(0, 5, 6);
        ramp(0, 7);
        chk("abort_pre_elapsed", 64'(elapsed[0 +: LW]), 64'd2);
        counter = CW'(8);
        do_load(0, 10, 5);
        chk("abort_active", 64'(active[0]), 64'd0);
        chk("abort_done", 64'(done[0]), 64'd0);
        ramp(9, 20);

        // Edge lengths: len=1 on ch2, len=0 on ch3
        clear_all = 1; tick();
        do_load(2, 3, 1);
        do_load(3, 3, 0);
        ramp(0, 3);
        chk("len1_active", 64'(active[2]), 64'd1);
        counter = CW'(4); tick();
        chk("len1_done", 64'(done[2]), 64'd1);
        chk("len0_never", 64'(active[3]), 64'd0);
        ramp(5, 8);

        // len=255
        do_load(3, 1, 255);
        cnt = 0; maxel = 0;
        counter = CW'(1); tick();
        counter = CW'(2);
        for (int k = 0; k < 260; k++) begin
            cnt += int'(active[3]);
            if (int'(elapsed[3*LW +: LW]) > maxel) maxel = int'(elapsed[3*LW +: LW]);
            tick();
        end
        chk("len255_cycles", 64'(cnt), 64'd255);
        chk("len255_max_elapsed", 64'(maxel), 64'd254);

        // Async reset mid-window
        do_load(0, 2, 10);
        ramp(0, 5);
        #2;
        reset = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clock); #1;
        reset = 1;

        // clear_all with same-cycle load: load discarded
        do_load(1, 3, 2);
        clear_all = 1; load = 1; load_channel = 2'd0; load_start = CW'(3); load_length = LW'(2);
        tick();
        ramp(0, 8);
        chk("clear_load_discarded", 64'(any_active), 64'd0);

        // Randomized traffic
        counter = '0;
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                load = 1; load_channel = IW'($urandom_range(0, CH - 1));
                load_start = CW'($urandom_range(0, 40));
                load_length = LW'(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12));
            end
            if (r == 8) clear_all = 1;
            if (counter >= CW'(40)) begin
                counter = '0; counter_wrap = 1;
            end else if (r >= 9 && r < 12) begin
                counter = counter + CW'(3);
            end else begin
                counter = counter + CW'(1);
            end
            if (r == 12) counter_wrap = 1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
